// File: rtl/pkt_dist_pkg.sv
// Shared definitions for packet_distributor: register map, reset values,
// AXI response codes, FSM states and the lane-selection helper.
package pkt_dist_pkg;

    localparam int unsigned IDX_W = 5;

    localparam logic [IDX_W-1:0] REG_PACKET_SIZE       = 5'd0;
    localparam logic [IDX_W-1:0] REG_PACKETS_PER_GROUP = 5'd1;
    localparam logic [IDX_W-1:0] REG_OUTPUT_MASK       = 5'd2;
    localparam logic [IDX_W-1:0] REG_CTRL              = 5'd3;
    localparam logic [IDX_W-1:0] REG_STATUS            = 5'd4;
    localparam int unsigned      REG_STATS_BASE        = 8;

    localparam logic [15:0] RST_PACKET_SIZE       = 16'd4096;
    localparam logic [15:0] RST_PACKETS_PER_GROUP = 16'd1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Next set mask bit above cur, wrapping at nout; cur itself if it is the only one.
    function automatic logic [2:0] next_lane(input logic [7:0] mask,
                                             input logic [2:0] cur,
                                             input int unsigned nout);
        logic [2:0] sel;
        logic [2:0] idx;
        sel = cur;
        for (int unsigned k = 8; k >= 1; k--) begin
            if (k <= nout) begin
                idx = 3'((32'(cur) + k) % nout);
                if (mask[idx]) sel = idx;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave front end: turns AW/W and AR handshakes into single-cycle
// register requests (word index within a 128-byte window) and registers responses.
module axi4_lite_slave
    import pkt_dist_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      aw_addr,
    input  logic             aw_valid,
    output logic             aw_ready,
    input  logic [31:0]      w_data,
    input  logic [3:0]       w_strb,
    input  logic             w_valid,
    output logic             w_ready,
    output logic [1:0]       b_resp,
    output logic             b_valid,
    input  logic             b_ready,
    input  logic [31:0]      ar_addr,
    input  logic             ar_valid,
    output logic             ar_ready,
    output logic [31:0]      r_data,
    output logic [1:0]       r_resp,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             wr_req_c,
    output logic [IDX_W-1:0] wr_idx_c,
    output logic [31:0]      wr_data_c,
    output logic [3:0]       wr_strb_c,
    input  logic [1:0]       wr_resp,
    output logic             rd_req_c,
    output logic [IDX_W-1:0] rd_idx_c,
    input  logic [31:0]      rd_data,
    input  logic [1:0]       rd_resp
);

    logic unused_addr;

    // Request decode; upper address bits belong to the window base decoded upstream.
    always_comb begin
        wr_req_c    = aw_ready & aw_valid & w_valid;
        wr_idx_c    = aw_addr[6:2];
        wr_data_c   = w_data;
        wr_strb_c   = w_strb;
        rd_req_c    = ar_ready & ar_valid;
        rd_idx_c    = ar_addr[6:2];
        unused_addr = ^{aw_addr[31:7], aw_addr[1:0], ar_addr[31:7], ar_addr[1:0]};
    end

    // Write channel: accept AW and W together, one transaction outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
        end else begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            if (wr_req_c) begin
                b_valid <= 1'b1;
                b_resp  <= wr_resp;
            end else if (b_valid && b_ready) begin
                b_valid <= 1'b0;
            end
            if (!aw_ready && !b_valid && aw_valid && w_valid) begin
                aw_ready <= 1'b1;
                w_ready  <= 1'b1;
            end
        end
    end

    // Read channel: one transaction outstanding, data captured on the AR handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= 32'd0;
            r_resp   <= RESP_OKAY;
        end else begin
            ar_ready <= 1'b0;
            if (rd_req_c) begin
                r_valid <= 1'b1;
                r_data  <= rd_data;
                r_resp  <= rd_resp;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
            if (!ar_ready && !r_valid && ar_valid) begin
                ar_ready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_distributor.sv
// Round-robin packet distributor: splits one AXI-Stream into fixed-size
// packets and steers groups of packets across the lanes enabled in a mask.
// Optional per-lane packet counters: define PKT_DIST_STATS_EN.
module packet_distributor
    import pkt_dist_pkg::*;
#(
    parameter int unsigned DW   = 512,
    parameter int unsigned NOUT = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          S_AXI_AWADDR,
    input  logic                 S_AXI_AWVALID,
    output logic                 S_AXI_AWREADY,
    input  logic [31:0]          S_AXI_WDATA,
    input  logic [3:0]           S_AXI_WSTRB,
    input  logic                 S_AXI_WVALID,
    output logic                 S_AXI_WREADY,
    output logic [1:0]           S_AXI_BRESP,
    output logic                 S_AXI_BVALID,
    input  logic                 S_AXI_BREADY,
    input  logic [31:0]          S_AXI_ARADDR,
    input  logic                 S_AXI_ARVALID,
    output logic                 S_AXI_ARREADY,
    output logic [31:0]          S_AXI_RDATA,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RVALID,
    input  logic                 S_AXI_RREADY,
    input  logic [DW-1:0]        AXIS_IN_TDATA,
    input  logic                 AXIS_IN_TVALID,
    output logic                 AXIS_IN_TREADY,
    output logic [NOUT*DW-1:0]   AXIS_OUT_TDATA,
    output logic [NOUT-1:0]      AXIS_OUT_TLAST,
    output logic [NOUT-1:0]      AXIS_OUT_TVALID,
    input  logic [NOUT-1:0]      AXIS_OUT_TREADY,
    output logic [15:0]          PACKET_SIZE
);

    localparam int unsigned BPB = DW / 8;

    logic             wr_req, rd_req;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_data, rd_data;
    logic [3:0]       wr_strb;
    logic [1:0]       wr_resp, rd_resp;
    logic             unused_wr;

    logic [15:0]      size_q, group_q;
    logic [NOUT-1:0]  mask_q;
    logic             en_q, clr_q;

    logic [15:0]      sh_size_q, sh_group_q;
    logic [NOUT-1:0]  sh_mask_q;
    logic [15:0]      cyc_q, pkt_q;
    logic [2:0]       lane_q;
    state_t           state_q, state_d;

    logic [15:0]      cpp_c, grp_c, div_c;
    logic [7:0]       mask8_c, sh_mask8_c, rdy8_c;
    logic             running_c, last_c, hs_c, boundary_c, group_end_c, start_c;

    axi4_lite_slave u_axil (
        .clk       (clk),
        .resetn    (resetn),
        .aw_addr   (S_AXI_AWADDR),
        .aw_valid  (S_AXI_AWVALID),
        .aw_ready  (S_AXI_AWREADY),
        .w_data    (S_AXI_WDATA),
        .w_strb    (S_AXI_WSTRB),
        .w_valid   (S_AXI_WVALID),
        .w_ready   (S_AXI_WREADY),
        .b_resp    (S_AXI_BRESP),
        .b_valid   (S_AXI_BVALID),
        .b_ready   (S_AXI_BREADY),
        .ar_addr   (S_AXI_ARADDR),
        .ar_valid  (S_AXI_ARVALID),
        .ar_ready  (S_AXI_ARREADY),
        .r_data    (S_AXI_RDATA),
        .r_resp    (S_AXI_RRESP),
        .r_valid   (S_AXI_RVALID),
        .r_ready   (S_AXI_RREADY),
        .wr_req_c  (wr_req),
        .wr_idx_c  (wr_idx),
        .wr_data_c (wr_data),
        .wr_strb_c (wr_strb),
        .wr_resp   (wr_resp),
        .rd_req_c  (rd_req),
        .rd_idx_c  (rd_idx),
        .rd_data   (rd_data),
        .rd_resp   (rd_resp)
    );

`ifdef PKT_DIST_STATS_EN
    logic [31:0] stats_q [NOUT];

    // Per-lane completed-packet counters, cleared by the self-clearing CTRL bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NOUT; i++) stats_q[i] <= 32'd0;
        end else begin
            for (int i = 0; i < NOUT; i++) begin
                if (clr_q) stats_q[i] <= 32'd0;
                else if (boundary_c && lane_q == 3'(i)) stats_q[i] <= stats_q[i] + 32'd1;
            end
        end
    end
`endif

    // Datapath helpers: packet length in beats, effective group size, handshakes.
    always_comb begin
        div_c       = sh_size_q / 16'(BPB);
        cpp_c       = (div_c == 16'd0) ? 16'd1 : div_c;
        grp_c       = (sh_group_q == 16'd0) ? 16'd1 : sh_group_q;
        mask8_c     = 8'(mask_q);
        sh_mask8_c  = 8'(sh_mask_q);
        rdy8_c      = 8'(AXIS_OUT_TREADY);
        running_c   = (state_q == ST_RUN);
        last_c      = (cyc_q == cpp_c);
        hs_c        = running_c & AXIS_IN_TVALID & rdy8_c[lane_q];
        boundary_c  = hs_c & last_c;
        group_end_c = boundary_c & (pkt_q >= grp_c);
        unused_wr   = ^{wr_data[31:16], wr_strb[3:2], rd_req};
    end

    // Register access responses and read mux.
    always_comb begin
        wr_resp = (wr_idx <= REG_CTRL) ? RESP_OKAY : RESP_DECERR;
        rd_resp = RESP_OKAY;
        rd_data = 32'd0;
        case (rd_idx)
            REG_PACKET_SIZE:       rd_data = 32'(size_q);
            REG_PACKETS_PER_GROUP: rd_data = 32'(group_q);
            REG_OUTPUT_MASK:       rd_data = 32'(mask_q);
            REG_CTRL:              rd_data = 32'(en_q);
            REG_STATUS:            rd_data = {21'd0, lane_q, 7'd0, running_c};
            default:               rd_resp = RESP_DECERR;
        endcase
`ifdef PKT_DIST_STATS_EN
        for (int i = 0; i < NOUT; i++) begin
            if (wr_idx == 5'(REG_STATS_BASE + i)) wr_resp = RESP_OKAY;
            if (rd_idx == 5'(REG_STATS_BASE + i)) begin
                rd_data = stats_q[i];
                rd_resp = RESP_OKAY;
            end
        end
`endif
    end

    // Configuration registers with byte strobes; clear-stats is a one-cycle pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            size_q  <= RST_PACKET_SIZE;
            group_q <= RST_PACKETS_PER_GROUP;
            mask_q  <= '1;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            if (wr_req) begin
                case (wr_idx)
                    REG_PACKET_SIZE: begin
                        if (wr_strb[0]) size_q[7:0]  <= wr_data[7:0];
                        if (wr_strb[1]) size_q[15:8] <= wr_data[15:8];
                    end
                    REG_PACKETS_PER_GROUP: begin
                        if (wr_strb[0]) group_q[7:0]  <= wr_data[7:0];
                        if (wr_strb[1]) group_q[15:8] <= wr_data[15:8];
                    end
                    REG_OUTPUT_MASK: if (wr_strb[0]) mask_q <= wr_data[NOUT-1:0];
                    REG_CTRL: if (wr_strb[0]) begin
                        en_q  <= wr_data[0];
                        clr_q <= wr_data[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: leave RUN only at a packet boundary.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        case (state_q)
            ST_IDLE: if (en_q && mask_q != '0) begin
                state_d = ST_RUN;
                start_c = 1'b1;
            end
            ST_RUN: if (boundary_c && (!en_q || mask_q == '0)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat/packet counters, lane selection and shadow configuration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_q      <= 16'd1;
            pkt_q      <= 16'd1;
            lane_q     <= 3'd0;
            sh_size_q  <= RST_PACKET_SIZE;
            sh_group_q <= RST_PACKETS_PER_GROUP;
            sh_mask_q  <= '1;
        end else if (start_c) begin
            cyc_q      <= 16'd1;
            pkt_q      <= 16'd1;
            sh_size_q  <= size_q;
            sh_group_q <= group_q;
            sh_mask_q  <= mask_q;
            if (!mask8_c[lane_q]) lane_q <= next_lane(mask8_c, lane_q, NOUT);
        end else if (hs_c) begin
            if (last_c) begin
                cyc_q      <= 16'd1;
                sh_size_q  <= size_q;
                sh_group_q <= group_q;
                sh_mask_q  <= mask_q;
                if (group_end_c) begin
                    pkt_q  <= 16'd1;
                    lane_q <= next_lane(sh_mask8_c, lane_q, NOUT);
                end else begin
                    pkt_q <= pkt_q + 16'd1;
                end
            end else begin
                cyc_q <= cyc_q + 16'd1;
            end
        end
    end

    // Stream steering: data fans out to all lanes, valid/last only on the selected one.
    always_comb begin
        AXIS_OUT_TDATA  = {NOUT{AXIS_IN_TDATA}};
        AXIS_OUT_TVALID = '0;
        AXIS_OUT_TLAST  = '0;
        AXIS_IN_TREADY  = running_c & rdy8_c[lane_q];
        PACKET_SIZE     = sh_size_q;
        for (int i = 0; i < NOUT; i++) begin
            if (running_c && lane_q == 3'(i)) begin
                AXIS_OUT_TVALID[i] = AXIS_IN_TVALID;
                AXIS_OUT_TLAST[i]  = last_c;
            end
        end
    end

endmodule

// File: tb/tb_packet_distributor.sv
// Scoreboard bench for packet_distributor (DW=512, NOUT=4).
module tb_packet_distributor;

    localparam int DW   = 512;
    localparam int NOUT = 4;
    localparam int BPB  = DW / 8;

    logic                clk, resetn;
    logic [31:0]         S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic                S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [3:0]          S_AXI_WSTRB;
    logic [1:0]          S_AXI_BRESP, S_AXI_RRESP;
    logic                S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic                S_AXI_RVALID, S_AXI_RREADY;
    logic [DW-1:0]       AXIS_IN_TDATA;
    logic                AXIS_IN_TVALID, AXIS_IN_TREADY;
    logic [NOUT*DW-1:0]  AXIS_OUT_TDATA;
    logic [NOUT-1:0]     AXIS_OUT_TLAST, AXIS_OUT_TVALID, AXIS_OUT_TREADY;
    logic [15:0]         PACKET_SIZE;

    packet_distributor #(.DW(DW), .NOUT(NOUT)) dut (
        .clk(clk), .resetn(resetn),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TVALID(AXIS_IN_TVALID), .AXIS_IN_TREADY(AXIS_IN_TREADY),
        .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TLAST(AXIS_OUT_TLAST),
        .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
        .PACKET_SIZE(PACKET_SIZE)
    );

    typedef struct {
        int lane;
        int data;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    last_lanes[$];
    int    last_flags[$];
    int    total, bad, beat_id;

    // Reference model state: programmed registers, shadows, counters.
    int r_size, r_group, r_mask, r_en;
    int s_size, s_group, s_mask;
    int m_cyc, m_pkt, m_lane, m_run;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_cpp();
        int c;
        c = s_size / BPB;
        return (c == 0) ? 1 : c;
    endfunction

    function automatic int m_next(input int mask, input int cur);
        for (int k = 1; k <= NOUT; k++) begin
            if (mask[(cur + k) % NOUT]) return (cur + k) % NOUT;
        end
        return cur;
    endfunction

    task automatic m_reset();
        r_size = 4096; r_group = 1; r_mask = 4'hF; r_en = 0;
        s_size = 4096; s_group = 1; s_mask = 4'hF;
        m_cyc = 1; m_pkt = 1; m_lane = 0; m_run = 0;
    endtask

    task automatic m_advance();
        int gsz;
        if (m_cyc == m_cpp()) begin
            m_cyc = 1;
            gsz = (s_group == 0) ? 1 : s_group;
            if (m_pkt >= gsz) begin
                m_pkt  = 1;
                m_lane = m_next(s_mask, m_lane);
            end else begin
                m_pkt++;
            end
            s_size = r_size; s_group = r_group; s_mask = r_mask;
            if (r_en == 0 || r_mask == 0) m_run = 0;
        end else begin
            m_cyc++;
        end
    endtask

    task automatic axi_write(input int idx, input int data, output logic [1:0] resp);
        bit got;
        S_AXI_AWADDR = 32'(idx * 4); S_AXI_WDATA = data; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (S_AXI_AWREADY && S_AXI_WREADY) got = 1;
            @(posedge clk); #1;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        if (!got) check_eq("aw_timeout", 0, 1);
        S_AXI_BREADY = 1'b1;
        got = 0; resp = 2'bxx;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (S_AXI_BVALID) begin got = 1; resp = S_AXI_BRESP; end
            @(posedge clk); #1;
        end
        S_AXI_BREADY = 1'b0;
        if (!got) check_eq("b_timeout", 0, 1);
    endtask

    task automatic axi_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
        bit got;
        S_AXI_ARADDR = 32'(idx * 4); S_AXI_ARVALID = 1'b1;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (S_AXI_ARREADY) got = 1;
            @(posedge clk); #1;
        end
        S_AXI_ARVALID = 1'b0;
        if (!got) check_eq("ar_timeout", 0, 1);
        S_AXI_RREADY = 1'b1;
        got = 0; data = 'x; resp = 2'bxx;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (S_AXI_RVALID) begin got = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP; end
            @(posedge clk); #1;
        end
        S_AXI_RREADY = 1'b0;
        if (!got) check_eq("r_timeout", 0, 1);
    endtask

    // Configuration write that also updates the reference model.
    task automatic cfg(input int idx, input int val);
        logic [1:0] resp;
        axi_write(idx, val, resp);
        check_eq($sformatf("cfg_resp_%0d", idx), resp, 2'b00);
        case (idx)
            0: r_size  = val & 16'hFFFF;
            1: r_group = val & 16'hFFFF;
            2: r_mask  = val & 4'hF;
            3: r_en    = val & 1;
            default: ;
        endcase
        if (m_run == 0 && r_en != 0 && r_mask != 0) begin
            m_run = 1; m_cyc = 1; m_pkt = 1;
            s_size = r_size; s_group = r_group; s_mask = r_mask;
            if (!r_mask[m_lane]) m_lane = m_next(r_mask, m_lane);
        end
    endtask

    // Drive one beat; expectation is queued before the beat is offered.
    task automatic send_beat(input int stall);
        beat_t e;
        bit    got;
        e.lane = m_lane; e.data = beat_id; e.last = (m_cyc == m_cpp());
        exp_q.push_back(e);
        AXIS_IN_TDATA  = {(DW/32){beat_id}};
        AXIS_IN_TVALID = 1'b1;
        if (stall > 0) begin
            AXIS_OUT_TREADY[m_lane] = 1'b0;
            for (int c = 0; c < stall; c++) begin
                @(negedge clk);
                check_eq("stall_in_ready", AXIS_IN_TREADY, 0);
                check_eq("stall_sel_valid", AXIS_OUT_TVALID[m_lane], 1);
                check_eq("stall_other_valid", 32'(AXIS_OUT_TVALID & ~(4'(1) << m_lane)), 0);
            end
            @(posedge clk); #1;
            AXIS_OUT_TREADY = '1;
        end
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (AXIS_IN_TREADY) got = 1;
            @(posedge clk); #1;
        end
        AXIS_IN_TVALID = 1'b0;
        beat_id++;
        if (!got) check_eq("beat_timeout", 0, 1);
        else m_advance();
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send_beat(0);
    endtask

    task automatic do_reset();
        AXIS_IN_TVALID = 1'b0; AXIS_OUT_TREADY = '1;
        #1 resetn = 1'b0;
        m_reset();
        exp_q.delete(); last_lanes.delete(); last_flags.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    // Output monitor: pops the scoreboard on each accepted output beat.
    always @(negedge clk) begin : mon
        int    nv;
        beat_t e;
        nv = 0;
        for (int i = 0; i < NOUT; i++) if (AXIS_OUT_TVALID[i]) nv++;
        for (int i = 0; i < NOUT; i++) begin
            if (resetn && AXIS_OUT_TVALID[i] && AXIS_OUT_TREADY[i]) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", i, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat_lane", i, e.lane);
                    check_eq("beat_data_lo", AXIS_OUT_TDATA[i*DW +: 32], e.data);
                    check_eq("beat_data_hi", AXIS_OUT_TDATA[i*DW + DW - 32 +: 32], e.data);
                    check_eq("beat_last", AXIS_OUT_TLAST[i], e.last);
                    check_eq("one_valid", nv, 1);
                    last_flags.push_back(int'(AXIS_OUT_TLAST[i]));
                    if (AXIS_OUT_TLAST[i]) last_lanes.push_back(i);
                end
            end
        end
    end

    task automatic check_lanes(input string tag, input int exp_l[], input int n);
        check_eq({tag, "_count"}, last_lanes.size(), n);
        for (int i = 0; i < n && i < last_lanes.size(); i++)
            check_eq($sformatf("%s_%0d", tag, i), last_lanes[i], exp_l[i]);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        int exp1[]  = '{0,0,1,1,2,2,3,3};
        int exp2[]  = '{0,0,2,2,0,0,2,2,0,0,2,2,0,0,0,0};
        int exp3[]  = '{0,1,2};
        int flag3[] = '{0,0,0,1,0,1,0,1};
        int exp5[]  = '{0,1,2,3,0,1,2,3};
        total = 0; bad = 0; beat_id = 1;
        resetn = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
        S_AXI_RREADY = 0; AXIS_IN_TDATA = '0;

        // Reset state and register map.
        do_reset();
        check_eq("rst_in_ready", AXIS_IN_TREADY, 0);
        check_eq("rst_out_valid", AXIS_OUT_TVALID, 0);
        check_eq("rst_packet_size", PACKET_SIZE, 4096);
        axi_read(0, rd, rr); check_eq("rst_reg0", rd, 4096); check_eq("rst_reg0_resp", rr, 0);
        axi_read(1, rd, rr); check_eq("rst_reg1", rd, 1);
        axi_read(2, rd, rr); check_eq("rst_reg2", rd, 4'hF);
        axi_read(3, rd, rr); check_eq("rst_reg3", rd, 0);
        axi_read(4, rd, rr); check_eq("rst_status", rd, 0); check_eq("rst_status_resp", rr, 0);
        axi_read(5, rd, rr); check_eq("undef_rd_resp", rr, 2'b11);
        axi_write(4, 1, rr); check_eq("status_wr_resp", rr, 2'b11);
        axi_write(20, 1, rr); check_eq("undef_wr_resp", rr, 2'b11);
        axi_read(9, rd, rr);
`ifdef PKT_DIST_STATS_EN
        check_eq("stats9_resp", rr, 2'b00);
`else
        check_eq("stats9_resp", rr, 2'b11);
`endif

        // Size 256, group 2, mask 0xF: 8 packets of 4 beats on lanes 0,0,1,1,2,2,3,3.
        cfg(0, 256); cfg(1, 2); cfg(2, 4'hF); cfg(3, 1);
        send_n(28);
        axi_read(4, rd, rr); check_eq("status_lane3", rd, 32'h301);
        send_n(4);
        check_lanes("grp2", exp1, 8);
        // Abandon a partial packet with reset.
        send_n(2);
        do_reset();
        check_eq("rst2_in_ready", AXIS_IN_TREADY, 0);
        check_eq("rst2_out_valid", AXIS_OUT_TVALID, 0);

        // Mask 0x5 alternating lanes, then drop lane 2 mid-group.
        cfg(0, 64); cfg(1, 2); cfg(2, 4'h5); cfg(3, 1);
        send_n(8);
        send_n(3);
        cfg(2, 4'h1);
        send_n(5);
        check_lanes("mask", exp2, 16);

        // Size change mid-packet, then a stalled lane.
        do_reset();
        cfg(0, 256); cfg(1, 1); cfg(2, 4'hF); cfg(3, 1);
        send_n(2);
        cfg(0, 128);
        check_eq("psize_inflight", PACKET_SIZE, 256);
        send_n(2);
        check_eq("psize_next", PACKET_SIZE, 128);
        send_n(2);
        send_beat(5);
        send_n(1);
        check_lanes("resize", exp3, 3);
        check_eq("flags_count", last_flags.size(), 8);
        for (int i = 0; i < 8 && i < last_flags.size(); i++)
            check_eq($sformatf("flag_%0d", i), last_flags[i], flag3[i]);

        // Sub-beat packet sizes: every beat is a packet.
        do_reset();
        cfg(0, 0); cfg(1, 1); cfg(2, 4'hF); cfg(3, 1);
        send_n(4);
        cfg(0, 32);
        send_n(4);
        check_lanes("tiny", exp5, 8);

        repeat (4) @(posedge clk);
        check_eq("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_distributor.md
PACKET_DISTRIBUTOR -- requirements
Module: packet_distributor

Interface
REQ-001 SHALL have parameter DW, default 512, meaning stream data width in bits (multiple of 64).
REQ-002 SHALL have parameter NOUT, default 4, meaning number of output streams (2..8).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port S_AXI_*, slave, 32-bit addr/data, meaning the standard AXI4-Lite slave bundle (AW/W/B/AR/R), decoded through axi4_lite_slave with a 128-byte window.
REQ-006 SHALL have ports AXIS_IN_TDATA, AXIS_IN_TVALID and AXIS_IN_TREADY, in/in/out, DW/1/1, meaning the input frame stream.
REQ-007 SHALL have ports AXIS_OUT_TDATA, AXIS_OUT_TLAST, AXIS_OUT_TVALID and AXIS_OUT_TREADY, out/out/out/in, NOUT*DW/NOUT/NOUT/NOUT, meaning the output streams; lane i occupies slice i.
REQ-008 SHALL have port PACKET_SIZE, output, 16, meaning the active packet size in bytes.

Function
REQ-009 SHALL expose these 32-bit registers by index: 0 PACKET_SIZE (rw, [15:0]); 1 PACKETS_PER_GROUP (rw, [15:0]); 2 OUTPUT_MASK (rw, [NOUT-1:0]); 3 CTRL (rw, bit0 enable, bit1 clear-stats self-clearing); 4 STATUS (ro, bit0 running, [10:8] current lane).
REQ-010 SHALL return DECERR for any access to an undefined index and for any write to STATUS; all other accesses return OKAY.
REQ-011 SHALL keep shadow copies of packet size, group size and mask, loaded only on IDLE->RUN and at each packet boundary, so writes never disturb a packet in flight.
REQ-012 SHALL compute cycles-per-packet = shadow size / (DW/8), truncating; a result of 0 SHALL be treated as 1. Group size 0 SHALL be treated as 1.
REQ-013 SHALL implement a two-state FSM: IDLE->RUN when CTRL.enable=1 and OUTPUT_MASK!=0; RUN->IDLE at a packet boundary when enable=0 or the shadow mask would load as 0.
REQ-014 SHALL hold AXIS_IN_TREADY=0 and all AXIS_OUT_TVALID=0 in IDLE.
REQ-015 SHALL, in RUN, drive AXIS_IN_TDATA onto every lane with zero latency, assert TVALID only on the selected lane (TVALID = AXIS_IN_TVALID), and pass that lane's TREADY to AXIS_IN_TREADY.
REQ-016 SHALL assert TLAST on the selected lane during the beat whose cycle count equals cycles-per-packet; the cycle count runs 1..N and advances only on a TVALID&TREADY handshake.
REQ-017 SHALL count packets 1..group on handshakes with TLAST; at the group end, the selection SHALL advance to the next set mask bit above the current lane, wrapping from NOUT-1 to 0.
REQ-018 SHALL, if the current lane is cleared from the mask, leave it at the next group end; if the mask has exactly one bit set, stay on that lane.
REQ-019 SHALL make a new selection effective on the cycle after the TLAST handshake; no beat is ever duplicated or dropped.

Reset
REQ-020 SHALL, on resetn=0 asynchronously, enter IDLE, set cycle and packet counters to 1, set the lane to 0, set PACKET_SIZE to 4096, PACKETS_PER_GROUP to 1, OUTPUT_MASK to all ones and CTRL to 0, and clear all AXI responses.
REQ-021 SHALL abandon a packet in flight when reset is asserted mid-packet; no TLAST is generated for it.

Configuration
REQ-022 SHALL, when PKT_DIST_STATS_EN is defined, provide per-lane 32-bit packet counters at read-only indices 8+i that increment on each TLAST handshake, wrap at 2^32 and clear on CTRL.bit1.
REQ-023 SHALL, when PKT_DIST_STATS_EN is undefined, omit the counters and return DECERR at those indices.

Structure
REQ-024 SHALL take register indices, reset defaults and OKAY/SLVERR/DECERR codes from the shared package pkt_dist_pkg.
REQ-025 SHALL instantiate the existing axi4_lite_slave as its only sub-module; lane selection (next set bit with wrap) SHALL be implemented as a function in pkt_dist_pkg.

Verification
REQ-026 Bench SHALL cover: DW=512, size 256, group 2, mask 0xF, enable, 32 beats -> 8 packets with TLAST every 4th beat, on lanes 0,0,1,1,2,2,3,3.
REQ-027 Bench SHALL cover: mask 0x5 -> lanes cycle 0,2,0,2; clearing bit 2 mid-group -> lane 2 finishes its group, then stays on 0.
REQ-028 Bench SHALL cover: write size 128 mid-packet at size 256 -> current packet is 4 beats, the next is 2 beats.
REQ-029 Bench SHALL cover: lane TREADY low for 5 cycles -> AXIS_IN_TREADY low for those cycles, counts frozen, no other lane valid.
REQ-030 Bench SHALL cover: size 0, then 32 -> both give 1-beat packets with TLAST on every beat.
REQ-031 Bench SHALL cover: read index 4 while running on lane 3 -> 0x301; read index 9 without PKT_DIST_STATS_EN -> DECERR.
